// File: rtl/seq_barrel_shift_left_if.sv
// Operand/result bus for the sequential left shifter: valid/ready in, valid/ready out, plus busy.
// Latency: none; signal bundle only.
// Backpressure: out_ready stalls the result side, and in_ready gates the operand side.
// Optional feature macro: SEQ_SHL_ROTATE_EN adds the rot select bit.
interface seq_barrel_shift_left_if #(
    parameter int WIDTH = 32,
    parameter int AMT_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [AMT_W-1:0] in_amt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             busy;
`ifdef SEQ_SHL_ROTATE_EN
    logic             rot;

    modport master (
        output in_valid, in_data, in_amt, rot, out_ready,
        input  in_ready, out_valid, out_data, busy
    );
    modport slave (
        input  in_valid, in_data, in_amt, rot, out_ready,
        output in_ready, out_valid, out_data, busy
    );
`else
    modport master (
        output in_valid, in_data, in_amt, out_ready,
        input  in_ready, out_valid, out_data, busy
    );
    modport slave (
        input  in_valid, in_data, in_amt, out_ready,
        output in_ready, out_valid, out_data, busy
    );
`endif
endinterface

// File: rtl/seq_barrel_shift_left.sv
// Multi-cycle logical left shifter, one shift-amount bit per clock (MSB stage first).
// Latency: AMT_W clocks from the accept edge to out_valid, independent of the amount.
// Backpressure: the result is held in DONE until out_ready; no operand is taken until back in IDLE.
// Optional feature macro: SEQ_SHL_ROTATE_EN (rot=1 turns each stage into a rotate-left).
module seq_barrel_shift_left #(
    parameter int WIDTH = 32,
    parameter int AMT_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seq_barrel_shift_left_if.slave bus
);
    // Stage counter only has to hold AMT_W-1..0.
    localparam int SW = (AMT_W > 1) ? $clog2(AMT_W) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_step;
    logic [AMT_W-1:0] amt;
    logic [SW-1:0]    stage;
    logic [AMT_W-1:0] step;
    logic             accept;
`ifdef SEQ_SHL_ROTATE_EN
    logic             rot_q;
    logic [AMT_W:0]   back;
`endif

    // One stage of the shifter: move acc by 2^stage when this amount bit is set.
    always_comb begin
        step     = AMT_W'(1) << stage;
        acc_step = acc;
`ifdef SEQ_SHL_ROTATE_EN
        // step is never zero, so WIDTH-step stays below WIDTH and the wrap term is well defined.
        back = (AMT_W+1)'(WIDTH) - (AMT_W+1)'(step);
        if (amt[stage]) begin
            if (rot_q) begin
                acc_step = (acc << step) | (acc >> back);
            end else begin
                acc_step = acc << step;
            end
        end
`else
        if (amt[stage]) begin
            acc_step = acc << step;
        end
`endif
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs; DONE never asserts in_ready, so no accept on the output handshake.
    always_comb begin
        state_nxt     = state;
        accept        = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b1;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                bus.busy     = 1'b0;
                if (bus.in_valid) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (stage == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: capture the operand on accept, then apply one stage per SHIFT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            amt   <= '0;
            stage <= '0;
`ifdef SEQ_SHL_ROTATE_EN
            rot_q <= 1'b0;
`endif
        end else if (accept) begin
            acc   <= bus.in_data;
            amt   <= bus.in_amt;
            stage <= SW'(AMT_W - 1);
`ifdef SEQ_SHL_ROTATE_EN
            rot_q <= bus.rot;
`endif
        end else if (state == SHIFT) begin
            acc <= acc_step;
            if (stage != '0) begin
                stage <= stage - SW'(1);
            end
        end
    end

    // acc only changes in SHIFT, so it is stable for the whole DONE phase.
    assign bus.out_data = acc;

endmodule

// File: doc/seq_barrel_shift_left.md
Name: seq_barrel_shift_left

Overview:
- Multi-cycle logical left shifter; the left-shift counterpart of the datapath's 32-bit combinational right barrel shifter.
- Used by the message cipher/packing path, which must undo right-shift obfuscation.
- Processes one bit of the shift amount per clock: 16, 8, 4, 2, 1, in that order.
- valid/ready handshake on input and output; fixed latency regardless of shift amount.

Parameters:
- WIDTH, 32, data width in bits.
- AMT_W, 5, shift-amount width. Must satisfy 2^AMT_W == WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data/in_amt present.
- in_ready  output  1  block can accept an operand.
- in_data  input  WIDTH  value to shift.
- in_amt  input  AMT_W  left-shift amount, 0..WIDTH-1.
- out_valid  output  1  out_data holds a result.
- out_ready  input  1  consumer takes the result.
- out_data  output  WIDTH  shifted result, zero-filled from the LSB.
- busy  output  1  high in SHIFT or DONE.

Behaviour:
- Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, busy=0, out_data=0, internal data/amt/stage registers=0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: latch in_data into acc, latch in_amt, stage=AMT_W-1, go to SHIFT.
- SHIFT:
  - in_ready=0.
  - Each cycle: if amt[stage]=1 then acc <= acc << 2^stage (zero fill), else acc unchanged.
  - stage decrements each cycle. After processing stage 0, go to DONE.
  - Exactly AMT_W cycles in SHIFT.
- DONE:
  - out_valid=1; out_data=acc, held stable until accepted.
  - On out_ready: out_valid drops next cycle, go to IDLE.
  - No new operand is accepted in the same cycle as the output handshake.
- Latency: acceptance edge T leaves SHIFT at T+AMT_W, so out_valid is visible in the cycle after edge T+AMT_W (5 clocks for default).
- Throughput: at most one result per AMT_W+2 cycles when out_ready is held high.
- Width rules:
  - Result equals (in_data << in_amt) truncated to WIDTH.
  - Bits shifted past the MSB are discarded.
  - amt=0 returns in_data unchanged, with full latency.
- Boundaries:
  - in_valid while not in IDLE is ignored; the driver must hold the operand.
  - out_ready while not in DONE has no effect.
  - out_valid stays high indefinitely under backpressure.
  - rst_n low mid-SHIFT or mid-DONE: immediate return to reset values; the partial result is lost and out_valid is never seen.
  - in_data/in_amt changes after acceptance do not affect the in-flight result.

Optional Feature:
- Macro: SEQ_SHL_ROTATE_EN.
- When defined:
  - Adds input port rot (1 bit), latched with in_amt at acceptance.
  - rot=1: each stage performs a rotate-left by 2^stage (MSBs wrap into LSBs), so the result equals rotl(in_data, in_amt).
  - rot=0: behaviour is identical to the plain shifter.
- When undefined: no rot port; always a logical shift with zero fill. Latency is identical in both builds.

Test Plan:
- Reset, then in_data=32'h0000_0001, in_amt=5'd31 -> out_valid 5 cycles after accept, out_data=32'h8000_0000.
- in_data=32'hDEAD_BEEF, in_amt=0 -> out_data=32'hDEAD_BEEF after the same 5-cycle latency; in_ready=0 throughout SHIFT/DONE.
- in_data=32'hFFFF_FFFF, in_amt=5'd20 -> out_data=32'hFFF0_0000. Hold out_ready=0 for 10 cycles -> out_valid and out_data stable; in_valid pulses ignored.
- Back-to-back operands with out_ready=1: (32'h1234_5678, 4) then (32'h1234_5678, 16) -> 32'h2345_6780 then 32'h5678_0000, accepts 7 cycles apart.
- Assert rst_n=0 two cycles into SHIFT -> out_valid=0 and in_ready=1 immediately; a fresh operand (32'h1, 1) yields 32'h2.
- SEQ_SHL_ROTATE_EN: in_data=32'h8000_0001, in_amt=4, rot=1 -> 32'h0000_0018. Same operand with rot=0 -> 32'h0000_0010.
